// File: rtl/alu_pkg.sv
// Shared definitions for the SimpleRISC ALU execute stage.
// Opcode encodings, controller state encoding and divider iteration count.
package alu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] ALU_ADD = 5'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 5'd1;
  localparam logic [OP_W-1:0] ALU_MUL = 5'd2;
  localparam logic [OP_W-1:0] ALU_DIV = 5'd3;
  localparam logic [OP_W-1:0] ALU_MOD = 5'd4;
  localparam logic [OP_W-1:0] ALU_CMP = 5'd5;
  localparam logic [OP_W-1:0] ALU_AND = 5'd6;
  localparam logic [OP_W-1:0] ALU_OR  = 5'd7;
  localparam logic [OP_W-1:0] ALU_NOT = 5'd8;
  localparam logic [OP_W-1:0] ALU_MOV = 5'd9;
  localparam logic [OP_W-1:0] ALU_LSL = 5'd10;
  localparam logic [OP_W-1:0] ALU_LSR = 5'd11;
  localparam logic [OP_W-1:0] ALU_ASR = 5'd12;
  localparam logic [OP_W-1:0] ALU_LD  = 5'd14;
  localparam logic [OP_W-1:0] ALU_ST  = 5'd15;

  // One quotient bit per cycle for a 32-bit datapath.
  localparam int unsigned DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// The first iteration runs on the start edge, so done pulses one cycle after
// the final iteration and quotient/remainder are valid while done is high.
module alu_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] src_rem_c, src_quo_c, src_dvs_c;
  logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;
  logic [WIDTH:0]   trial_c, dvs_ext_c;
  logic             fits_c;

  // One restoring step; on start the step works directly on the new operands.
  always_comb begin
    src_rem_c = start ? '0 : rem_q;
    src_quo_c = start ? dividend : quo_q;
    src_dvs_c = start ? divisor : dvs_q;
    dvs_ext_c = {1'b0, src_dvs_c};
    trial_c   = {src_rem_c, src_quo_c[WIDTH-1]};
    fits_c    = (trial_c >= dvs_ext_c);
    rem_nxt_c = fits_c ? WIDTH'(trial_c - dvs_ext_c) : trial_c[WIDTH-1:0];
    quo_nxt_c = {src_quo_c[WIDTH-2:0], fits_c};
  end

  // Iteration counter, partial remainder and quotient shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nxt_c;
      quo_q  <= quo_nxt_c;
      dvs_q  <= divisor;
      cnt_q  <= CNT_W'(WIDTH - 1);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_nxt_c;
      quo_q  <= quo_nxt_c;
      cnt_q  <= cnt_q - CNT_W'(1);
      done_q <= (cnt_q == CNT_W'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: handshake, operand select, single-cycle ALU,
// E/GT flag register and result hold until writeback.
// Build option: define ALU_DIV_EN to build the iterative divider for div/mod;
// without it div/mod retire in one cycle with a zero result.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_immx,
  input  logic             in_is_imm,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             flag_e,
  output logic             flag_gt,
  output logic             busy
);

  localparam int unsigned SH_W = 5;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             flag_e_q, flag_e_d, flag_gt_q, flag_gt_d;
  logic [WIDTH-1:0] b_sel_c, alu_res_c;
  logic [SH_W-1:0]  shamt_c;
  logic             accept_c;

  assign in_ready = (state_q == ST_IDLE) && !flush;
  assign accept_c = in_valid && in_ready;
  assign b_sel_c  = in_is_imm ? in_immx : in_b;
  assign shamt_c  = b_sel_c[SH_W-1:0];

`ifdef ALU_DIV_EN
  logic             mod_q, mod_d;
  logic             div_start_c, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start_c),
    .clear     (flush),
    .dividend  (in_a),
    .divisor   (b_sel_c),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`endif

  // Single-cycle datapath on the live operands, registered at accept.
  always_comb begin
    alu_res_c = '0;
    case (in_op)
      ALU_ADD, ALU_LD, ALU_ST: alu_res_c = in_a + b_sel_c;
      ALU_SUB: alu_res_c = in_a - b_sel_c;
      ALU_MUL: alu_res_c = in_a * b_sel_c;
`ifdef ALU_DIV_EN
      // Only reaches the result register when the divisor is zero.
      ALU_DIV: alu_res_c = '1;
      ALU_MOD: alu_res_c = in_a;
`endif
      ALU_AND: alu_res_c = in_a & b_sel_c;
      ALU_OR:  alu_res_c = in_a | b_sel_c;
      ALU_NOT: alu_res_c = ~b_sel_c;
      ALU_MOV: alu_res_c = b_sel_c;
      ALU_LSL: alu_res_c = in_a << shamt_c;
      ALU_LSR: alu_res_c = in_a >> shamt_c;
      ALU_ASR: alu_res_c = $unsigned($signed(in_a) >>> shamt_c);
      default: alu_res_c = '0;
    endcase
  end

  // Next-state, result capture and flag update; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    rd_d      = rd_q;
    flag_e_d  = flag_e_q;
    flag_gt_d = flag_gt_q;
`ifdef ALU_DIV_EN
    mod_d       = mod_q;
    div_start_c = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          rd_d    = in_rd;
          res_d   = alu_res_c;
          state_d = ST_DONE;
          if (in_op == ALU_CMP) begin
            flag_e_d  = (in_a == b_sel_c);
            flag_gt_d = ($signed(in_a) > $signed(b_sel_c));
          end
`ifdef ALU_DIV_EN
          if (((in_op == ALU_DIV) || (in_op == ALU_MOD)) && (b_sel_c != '0)) begin
            state_d     = ST_DIV;
            div_start_c = 1'b1;
            mod_d       = (in_op == ALU_MOD);
          end
`endif
        end
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        if (div_done) begin
          res_d   = mod_q ? div_rem : div_quo;
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State, result, tag and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      rd_q      <= '0;
      flag_e_q  <= 1'b0;
      flag_gt_q <= 1'b0;
`ifdef ALU_DIV_EN
      mod_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      flag_e_q  <= flag_e_d;
      flag_gt_q <= flag_gt_d;
`ifdef ALU_DIV_EN
      mod_q     <= mod_d;
`endif
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = res_q;
  assign out_rd     = rd_q;
  assign flag_e     = flag_e_q;
  assign flag_gt    = flag_gt_q;

endmodule
